sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
- Converts the two SRAM-like master ports driven by the SRAM arbiter (instruction and data) into a single AXI3 master port toward the SoC interconnect.
- Holds one outstanding transaction at a time. The data port has priority over the instruction port.
- Sits directly downstream of the SRAM arbiter and produces its addr_ok, data_ok and rdata responses.

Parameters:
- ID_INST, 4'd0, AXI arid/awid used for instruction-port transactions.
- ID_DATA, 4'd1, AXI arid/awid used for data-port transactions.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst_req/inst_wr  in  1/1  instruction request / write flag.
- inst_size  in  2  0 = byte, 1 = half, 2 = word.
- inst_addr/inst_wdata  in  32/32  instruction address / write data.
- inst_rdata  out  32  instruction read data.
- inst_addr_ok/inst_data_ok  out  1/1  instruction address accepted / transaction complete.
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same as the inst_* ports, for the data port.
- arid/araddr/arsize  out  4/32/3  AXI read address channel payload.
- arvalid/arready  out/in  1/1  AXI read address handshake.
- rid/rdata  in  4/32  AXI read data channel payload.
- rvalid/rready  in/out  1/1  AXI read data handshake.
- awid/awaddr/awsize  out  4/32/3  AXI write address channel payload.
- awvalid/awready  out/in  1/1  AXI write address handshake.
- wdata/wstrb  out  32/4  AXI write data channel payload.
- wvalid/wready  out/in  1/1  AXI write data handshake.
- bvalid/bready  in/out  1/1  AXI write response handshake.
- len, burst, lock, cache and prot are tied at the top wrapper and are not ports: single beat, INCR, 0.

Behaviour:
- States are IDLE, RD_ADDR, RD_DATA, WR_ADDR and WR_RESP. Reset forces IDLE immediately (asynchronous).
- Reset values:
  - All valid/ready outputs and all addr_ok/data_ok outputs are 0.
  - Latched address, size, wdata and source registers are 0.
  - aw_done and w_done are 0.
- IDLE, request acceptance:
  - If data_req=1: data_addr_ok=1 combinationally in the same cycle. Latch data_addr, data_size, data_wdata, data_wr and src=DATA.
  - Else if inst_req=1: inst_addr_ok=1 with the same latch, src=INST.
  - addr_ok is asserted only in IDLE.
  - Next state is WR_ADDR when wr=1, otherwise RD_ADDR.
- RD_ADDR:
  - arvalid=1; araddr/arsize come from the latched values; arsize={1'b0,size}; arid comes from src.
  - On arready, go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, pulse <src>_data_ok=1 for exactly one cycle. <src>_rdata=rdata combinationally. Return to IDLE.
  - The rid mismatch is ignored, because only one transaction is outstanding.
- WR_ADDR:
  - awvalid=!aw_done and wvalid=!w_done. Set each done flag on its own handshake.
  - Move to WR_RESP once both handshakes have completed, including both completing in the same cycle. Clear both flags on exit.
- wstrb derivation:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2: 4'b1111.
  - size 3 (illegal): 4'b0000.
  - wdata is the latched wdata, unshifted.
- WR_RESP:
  - bready=1.
  - On bvalid, pulse <src>_data_ok for one cycle and return to IDLE. bresp is ignored.
- rdata on both ports reads 0 whenever its data_ok is 0.
- Minimum latency with an always-ready slave: addr_ok at cycle 0, AR at cycle 1, data_ok at cycle 2. Writes take the same.
- A new request may be accepted in the cycle after data_ok.
- A req held across a busy period simply waits; no request is dropped.
- Reset asserted mid-transaction aborts it; no data_ok is generated for it.
- Starvation of inst under continuous data_req is accepted by design, because the upstream arbiter serialises its requests.

Test Plan:
- Inst read at 0xBFC00000, slave arready/rvalid immediate with rdata=0x3C1D0001:
  - inst_addr_ok at cycle 0, arid=0, arsize=3'b010.
  - inst_data_ok with inst_rdata=0x3C1D0001 at cycle 2.
- Data byte write, addr 0x80001002, size 0:
  - awaddr=0x80001002, wstrb=4'b0100, awid=1.
  - awready delayed 3 cycles and wready immediate → single data_data_ok after bvalid.
- Half write at addr[1]=1 → wstrb=4'b1100. Word write → wstrb=4'b1111.
- Simultaneous inst_req and data_req in IDLE:
  - data_addr_ok=1 and inst_addr_ok=0 in that cycle.
  - The inst request is accepted in the first IDLE cycle after data_data_ok.
- rvalid held low for 5 cycles during RD_DATA:
  - rready stays 1 throughout.
  - No data_ok until rvalid.
  - No addr_ok is issued to a pending inst_req.
- Reset pulled low while in WR_ADDR with awvalid=1:
  - awvalid=0 and state IDLE asynchronously.
  - After release, a fresh read completes normally.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - bridges the inst/data SRAM-like ports onto one single-outstanding AXI3 master
module sram_axi_bridge #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        src_q;      // 1 = data port owns the transaction
    logic        aw_done;
    logic        w_done;

    logic        accept;
    logic        accept_data;
    logic        aw_ok;
    logic        w_ok;
    logic        resp_fire;

    // Only one transaction is ever outstanding, so the returned ID carries no information.
    logic        rid_unused;
    assign rid_unused = ^rid;

    assign accept      = (state == IDLE) && (data_req || inst_req);
    assign accept_data = data_req;

    assign aw_ok = aw_done || awready;
    assign w_ok  = w_done || wready;

    always_comb begin
        state_nxt    = state;
        data_addr_ok = 1'b0;
        inst_addr_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        resp_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (data_req) begin
                    data_addr_ok = 1'b1;
                    state_nxt    = data_wr ? WR_ADDR : RD_ADDR;
                end else if (inst_req) begin
                    inst_addr_ok = 1'b1;
                    state_nxt    = inst_wr ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    resp_fire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_ADDR: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if (aw_ok && w_ok) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    resp_fire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            src_q   <= 1'b0;
        end else if (accept) begin
            src_q   <= accept_data;
            addr_q  <= accept_data ? data_addr  : inst_addr;
            wdata_q <= accept_data ? data_wdata : inst_wdata;
            size_q  <= accept_data ? data_size  : inst_size;
        end
    end

    // AW and W may complete in either order; the flags remember which one already has.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WR_ADDR) begin
            if (aw_ok && w_ok) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                aw_done <= aw_ok;
                w_done  <= w_ok;
            end
        end
    end

    always_comb begin
        wstrb = 4'b0000;
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            2'd2:    wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

    assign arid   = src_q ? ID_DATA : ID_INST;
    assign awid   = src_q ? ID_DATA : ID_INST;
    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;

    assign data_data_ok = resp_fire && src_q;
    assign inst_data_ok = resp_fire && !src_q;
    assign data_rdata   = (data_data_ok && state == RD_DATA) ? rdata : 32'd0;
    assign inst_rdata   = (inst_data_ok && state == RD_DATA) ? rdata : 32'd0;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - vector table, corner sequences and random traffic against a byte-memory model
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, rid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic [3:0]  wstrb;
    logic        wvalid, wready, bvalid, bready;

    int total = 0;
    int bad   = 0;

    logic [31:0] slave_mem [0:7];
    logic [7:0]  model_b   [0:31];

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Byte lanes covered by an access: the naturally aligned block of 1, 2 or 4 bytes holding addr.
    function automatic logic [3:0] lanes(input logic [1:0] size, input logic [31:0] a);
        int n, lo;
        logic [3:0] m;
        n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        lo = (n == 0) ? 0 : (int'(a[1:0]) / n) * n;
        for (int k = 0; k < 4; k++) m[k] = (n != 0) && (k >= lo) && (k < lo + n);
        return m;
    endfunction

    task automatic txn(input bit dport, input bit wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input int d_a, input int d_w, input int d_r,
                       input bit use_mem, input logic [31:0] srd, input logic [3:0] exp_strb,
                       output logic [31:0] got);
        logic [31:0] cap_a, cap_wd, rv;
        logic [3:0]  cap_s;
        logic [3:0]  exp_id;
        int          n;
        exp_id = dport ? 4'd1 : 4'd0;
        got    = 32'd0;
        cap_a  = 32'd0;
        cap_wd = 32'd0;
        cap_s  = 4'd0;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        if (dport) begin
            data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
        end else begin
            inst_req = 1'b1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
        end
        #1;
        chk("acc_own_addr_ok", {31'd0, dport ? data_addr_ok : inst_addr_ok}, 32'd1);
        chk("acc_other_addr_ok", {31'd0, dport ? inst_addr_ok : data_addr_ok}, 32'd0);
        chk("acc_data_ok_idle", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        @(posedge clk);
        if (!wr) begin
            for (int c = 0; c <= d_a; c++) begin
                @(negedge clk);
                if (dport) begin data_req = 1'b0; data_addr = $urandom; data_size = 2'($urandom); end
                else       begin inst_req = 1'b0; inst_addr = $urandom; inst_size = 2'($urandom); end
                arready = (c == d_a);
                #1;
                chk("ar_valid", {31'd0, arvalid}, 32'd1);
                chk("ar_addr", araddr, addr);
                chk("ar_size", {29'd0, arsize}, {29'd0, 1'b0, size});
                chk("ar_id", {28'd0, arid}, {28'd0, exp_id});
                chk("ar_busy_flags", {27'd0, rready, awvalid, wvalid, inst_addr_ok, data_addr_ok}, 32'd0);
                cap_a = araddr;
                @(posedge clk);
            end
            rv = use_mem ? slave_mem[cap_a[4:2]] : srd;
            for (int c = 0; c <= d_r; c++) begin
                @(negedge clk);
                arready = 1'b0;
                rvalid  = (c == d_r);
                rdata   = (c == d_r) ? rv : $urandom;
                rid     = exp_id;
                #1;
                chk("r_ready", {31'd0, rready}, 32'd1);
                chk("r_own_data_ok", {31'd0, dport ? data_data_ok : inst_data_ok}, {31'd0, c == d_r});
                chk("r_other_data_ok", {31'd0, dport ? inst_data_ok : data_data_ok}, 32'd0);
                chk("r_own_rdata", dport ? data_rdata : inst_rdata, (c == d_r) ? rv : 32'd0);
                chk("r_other_rdata", dport ? inst_rdata : data_rdata, 32'd0);
                chk("r_addr_ok_busy", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
                if (c == d_r) got = dport ? data_rdata : inst_rdata;
                @(posedge clk);
            end
        end else begin
            n = (d_a > d_w) ? d_a : d_w;
            for (int c = 0; c <= n; c++) begin
                @(negedge clk);
                if (dport) begin data_req = 1'b0; data_addr = $urandom; data_wdata = $urandom; end
                else       begin inst_req = 1'b0; inst_addr = $urandom; inst_wdata = $urandom; end
                awready = (c == d_a);
                wready  = (c == d_w);
                #1;
                chk("aw_valid", {31'd0, awvalid}, {31'd0, c <= d_a});
                chk("w_valid", {31'd0, wvalid}, {31'd0, c <= d_w});
                chk("w_busy_flags", {28'd0, arvalid, bready, inst_addr_ok, data_addr_ok}, 32'd0);
                if (c <= d_a) begin
                    chk("aw_addr", awaddr, addr);
                    chk("aw_size", {29'd0, awsize}, {29'd0, 1'b0, size});
                    chk("aw_id", {28'd0, awid}, {28'd0, exp_id});
                end
                if (c == d_a) cap_a = awaddr;
                if (c <= d_w) begin
                    chk("w_data", wdata, wd);
                    chk("w_strb", {28'd0, wstrb}, {28'd0, exp_strb});
                end
                if (c == d_w) begin cap_wd = wdata; cap_s = wstrb; end
                @(posedge clk);
            end
            if (use_mem)
                for (int k = 0; k < 4; k++)
                    if (cap_s[k]) slave_mem[cap_a[4:2]][8*k +: 8] = cap_wd[8*k +: 8];
            for (int c = 0; c <= d_r; c++) begin
                @(negedge clk);
                awready = 1'b0; wready = 1'b0;
                bvalid  = (c == d_r);
                #1;
                chk("b_ready", {31'd0, bready}, 32'd1);
                chk("b_own_data_ok", {31'd0, dport ? data_data_ok : inst_data_ok}, {31'd0, c == d_r});
                chk("b_other_data_ok", {31'd0, dport ? inst_data_ok : data_data_ok}, 32'd0);
                chk("b_rdata_zero", inst_rdata | data_rdata, 32'd0);
                chk("b_aw_w_idle", {30'd0, awvalid, wvalid}, 32'd0);
                @(posedge clk);
            end
        end
    endtask

    typedef struct {
        bit          dport;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] srd;
        int          d_a;
        int          d_w;
        int          d_r;
        logic [3:0]  strb;
    } vec_t;

    vec_t vecs [0:8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, exp, a, wd;
        logic [1:0]  sz;
        logic [3:0]  m;
        bit          dp, wr;

        vecs[0] = '{1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'h0,        32'h3C1D0001, 0, 0, 0, 4'b0000};
        vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h80001002, 32'h11223344, 32'h0,        3, 0, 1, 4'b0100};
        vecs[2] = '{1'b1, 1'b1, 2'd1, 32'h80001002, 32'hA5A5C3C3, 32'h0,        0, 0, 0, 4'b1100};
        vecs[3] = '{1'b0, 1'b1, 2'd1, 32'h80001000, 32'h0000BEEF, 32'h0,        1, 1, 0, 4'b0011};
        vecs[4] = '{1'b1, 1'b1, 2'd2, 32'h80001004, 32'hCAFEF00D, 32'h0,        0, 0, 2, 4'b1111};
        vecs[5] = '{1'b1, 1'b1, 2'd0, 32'h80001003, 32'h00000077, 32'h0,        0, 2, 0, 4'b1000};
        vecs[6] = '{1'b1, 1'b1, 2'd3, 32'h80001000, 32'h12345678, 32'h0,        0, 0, 0, 4'b0000};
        vecs[7] = '{1'b1, 1'b0, 2'd1, 32'h80002000, 32'h0,        32'hDEADBEEF, 1, 0, 2, 4'b0000};
        vecs[8] = '{1'b0, 1'b1, 2'd0, 32'h00000001, 32'h0000AB00, 32'h0,        0, 2, 1, 4'b0010};

        for (int i = 0; i < 8; i++) slave_mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) model_b[i] = 8'd0;

        reset = 1'b0;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'd0; inst_wdata = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rid = 4'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_handshakes", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("reset_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
        chk("reset_latches", {araddr[31:2], arsize[1:0]} | wdata | {28'd0, arid}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].dport, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wd,
                vecs[i].d_a, vecs[i].d_w, vecs[i].d_r, 1'b0, vecs[i].srd, vecs[i].strb, got);
            if (!vecs[i].wr) chk("vec_rdata", got, vecs[i].srd);
        end

        // Both ports request together; inst stays pending through a slow data read.
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC00010; inst_wdata = 32'd0;
        txn(1'b1, 1'b0, 2'd2, 32'h80004000, 32'd0, 0, 0, 5, 1'b0, 32'h0BADF00D, 4'b0000, got);
        chk("prio_data_rdata", got, 32'h0BADF00D);
        txn(1'b0, 1'b0, 2'd2, 32'hBFC00010, 32'd0, 0, 0, 0, 1'b0, 32'h24080004, 4'b0000, got);
        chk("pending_inst_rdata", got, 32'h24080004);

        // Reset in the middle of a write address phase.
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h80003000; data_wdata = 32'h55AA55AA;
        #1;
        chk("rst_seq_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        data_req = 1'b0;
        #1;
        chk("rst_seq_awvalid_before", {31'd0, awvalid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_async_aw_w", {30'd0, awvalid, wvalid}, 32'd0);
        chk("rst_async_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
        chk("rst_async_addr", awaddr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_held_idle", {28'd0, awvalid, wvalid, arvalid, bready}, 32'd0);
        reset = 1'b1;
        txn(1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'd0, 0, 0, 0, 1'b0, 32'h3C1D0001, 4'b0000, got);
        chk("after_reset_rdata", got, 32'h3C1D0001);

        // Random traffic into a small window; reads must return what the byte model holds.
        for (int i = 0; i < 40; i++) begin
            dp = 1'($urandom);
            wr = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            a  = 32'h10000000 | 32'($urandom_range(0, 31));
            wd = $urandom;
            m  = lanes(sz, a);
            txn(dp, wr, sz, a, wd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'b1, 32'd0, m, got);
            if (wr) begin
                for (int k = 0; k < 4; k++)
                    if (m[k]) model_b[int'(a[4:2]) * 4 + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < 4; k++) exp[8*k +: 8] = model_b[int'(a[4:2]) * 4 + k];
                chk("rand_rdata", got, exp);
            end
        end

        @(negedge clk);
        bvalid = 1'b0; rvalid = 1'b0;
        #1;
        chk("final_idle_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
